// File: rtl/pe_regfile_pkg.sv
// Shared definitions for the multi-port PE register file: FSM state
// encodings, default geometry and an address-validity helper.
package pe_regfile_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_NUM_RD     = 4;
    localparam int DEF_NUM_WR     = 2;

    // True when addr names a real, writable register (not hardwired zero).
    function automatic logic addr_ok(input int unsigned addr,
                                     input int unsigned num_regs,
                                     input logic        zero_reg);
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/pe_regfile_scoreboard.sv
// Busy scoreboard for long-latency results: a register is reserved at
// issue and released by any accepted writeback to it. Provides the
// reservation stall and per-read-port busy lookup (write-masked so it
// agrees with the data bypass).
module pe_regfile_scoreboard
    import pe_regfile_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         clr,
    input  logic [NUM_WR-1:0]            wr_acc,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic                         rsv_en,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic                         rsv_stall,
    output logic [NUM_RD-1:0]            rd_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wmask;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                rsv_ok;
    logic                rsv_hit;
    logic                rsv_busy;
    logic                rsv_set;

    // Registers receiving an accepted write this cycle.
    always_comb begin
        wmask = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_acc[j]) wmask[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        end
    end

    // Reservation arbitration: a same-cycle writeback frees the register for the new owner.
    always_comb begin
        rsv_ok   = addr_ok(32'(rsv_addr), NUM_REGS, ZERO_REG != 0);
        rsv_hit  = 1'b0;
        rsv_busy = 1'b0;
        if (rsv_ok) begin
            rsv_hit  = wmask[rsv_addr];
            rsv_busy = busy[rsv_addr];
        end
        rsv_stall = run & rsv_en & rsv_busy & ~rsv_hit;
        rsv_set   = run & ~clr & rsv_en & rsv_ok & ~rsv_stall;
        busy_nxt  = busy & ~wmask;
        if (rsv_set) busy_nxt[rsv_addr] = 1'b1;
    end

    // Busy vector: wiped on reset, during a sweep and on a clear request.
    always_ff @(posedge clk) begin
        if (rst || !run || clr) busy <= '0;
        else                    busy <= busy_nxt;
    end

    // Busy lookup per read port, masked by same-cycle writebacks.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = 1'b0;
            if (run && addr_ok(32'(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), NUM_REGS, ZERO_REG != 0))
                rd_busy[i] = busy[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] &
                             ~wmask[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/pe_regfile_mp.sv
// Multi-port PE register file with write-to-read bypass, busy scoreboard
// and a hardware clear sweep after reset or on request.
// Optional macro PE_REGFILE_RDREG_EN: register rd_data/rd_busy (1-cycle
// read latency); undefined gives a purely combinational read path.
module pe_regfile_mp
    import pe_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         rsv_en,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr,
    output logic                         rsv_stall,
    input  logic                         clr_req,
    output logic                         ready
);

    logic [0:0]                  state;
    logic [ADDR_WIDTH-1:0]       idx;
    logic [DATA_WIDTH-1:0]       regs [NUM_REGS];
    logic                        run;
    logic [NUM_WR-1:0]           wr_acc;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_RD-1:0]           rd_busy_c;

    assign run   = (state == ST_RUN);
    assign ready = run;

    // Accepted writes: only while running, never alongside a clear request.
    always_comb begin
        for (int j = 0; j < NUM_WR; j++)
            wr_acc[j] = run & ~clr_req & wr_en[j] &
                        addr_ok(32'(wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]), NUM_REGS, ZERO_REG != 0);
    end

    // Clear FSM: sweep every register once, then run until a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else if (state == ST_CLEAR) begin
            idx <= idx + ADDR_WIDTH'(1);
            if (idx == ADDR_WIDTH'(NUM_REGS - 1)) begin
                state <= ST_RUN;
                idx   <= '0;
            end
        end else if (clr_req) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end
    end

    // Storage: sweep zeroes one entry per cycle; otherwise later ports override earlier ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                regs[idx] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_acc[j])
                        regs[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read mux: highest-index same-cycle write to the address bypasses the array.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (run && addr_ok(32'(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), NUM_REGS, ZERO_REG != 0)) begin
                rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_acc[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]))
                        rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    pe_regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .NUM_WR     (NUM_WR),
        .ZERO_REG   (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clr       (clr_req),
        .wr_acc    (wr_acc),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr   (rd_addr),
        .rsv_stall (rsv_stall),
        .rd_busy   (rd_busy_c)
    );

`ifdef PE_REGFILE_RDREG_EN
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_p1;
    logic [NUM_RD-1:0]            rd_busy_p1;

    // Read output stage: capture the comb view, zero after any clear cycle.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            rd_data_p1 <= '0;
            rd_busy_p1 <= '0;
        end else begin
            rd_data_p1 <= rd_data_c;
            rd_busy_p1 <= rd_busy_c;
        end
    end

    assign rd_data = rd_data_p1;
    assign rd_busy = rd_busy_p1;
`else
    assign rd_data = rd_data_c;
    assign rd_busy = rd_busy_c;
`endif

endmodule

// File: tb/tb_pe_regfile_mp.sv
// Bench for pe_regfile_mp: table of per-cycle vectors plus hand-built
// reset/clear sequences; read results go through a latency-aware queue.
module tb_pe_regfile_mp;

`ifdef PE_REGFILE_RDREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic [19:0] rd_addr;
    logic [127:0] rd_data;
    logic [3:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_stall;
    logic        clr_req;
    logic        ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  rsva;
        logic        clr;
        logic [4:0]  ra0;
        logic [4:0]  ra3;
        logic [31:0] e0;
        logic [31:0] e3;
        logic        eb0;
        logic        est;
    } vec_t;

    typedef struct {
        int          due;
        int          port;
        string       nm;
        logic [31:0] dat;
        logic        bsy;
        logic        chk_b;
    } sb_t;

    sb_t  sbq[$];
    vec_t vt[21];

    pe_regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_stall (rsv_stall),
        .clr_req   (clr_req),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Pop every read expectation that falls due in this cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            check(e.nm, rd_data[e.port*32 +: 32], e.dat);
            if (e.chk_b)
                check({e.nm, "_busy"}, {31'b0, rd_busy[e.port]}, {31'b0, e.bsy});
        end
    end

    function automatic vec_t vz();
        vec_t v;
        v = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic run_cycle(input vec_t v, input string nm, input logic exp_rdy);
        sb_t e;
        wr_en    = v.we;
        wr_addr  = {v.wa1, v.wa0};
        wr_data  = {v.wd1, v.wd0};
        rsv_en   = v.rsv;
        rsv_addr = v.rsva;
        clr_req  = v.clr;
        rd_addr  = {v.ra3, 5'd0, 5'd0, v.ra0};
        e = '{cyc + LAT, 0, {nm, "_rd0"}, v.e0, v.eb0, 1'b1};
        sbq.push_back(e);
        e = '{cyc + LAT, 3, {nm, "_rd3"}, v.e3, 1'b0, 1'b0};
        sbq.push_back(e);
        @(negedge clk);
        check({nm, "_ready"}, {31'b0, ready}, {31'b0, exp_rdy});
        check({nm, "_stall"}, {31'b0, rsv_stall}, {31'b0, v.est});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //        we     wa0    wd0            wa1    wd1         rsv   rsva   clr   ra0    ra3    e0             e3           eb0   est
        vt[0]  = '{2'b11, 5'd5,  32'hAAAA,      5'd5,  32'h5555,   1'b0, 5'd0,  1'b0, 5'd5,  5'd5,  32'h5555,      32'h5555,    1'b0, 1'b0};
        vt[1]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  32'h5555,      32'h0,       1'b0, 1'b0};
        vt[2]  = '{2'b01, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0,      1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,         32'h0,       1'b0, 1'b0};
        vt[3]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,         32'h5555,    1'b0, 1'b0};
        vt[4]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b1, 5'd7,  1'b0, 5'd7,  5'd0,  32'h0,         32'h0,       1'b0, 1'b0};
        vt[5]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b1, 5'd7,  1'b0, 5'd7,  5'd0,  32'h0,         32'h0,       1'b1, 1'b1};
        vt[6]  = '{2'b01, 5'd7,  32'h1234,      5'd0,  32'h0,      1'b1, 5'd7,  1'b0, 5'd7,  5'd7,  32'h1234,      32'h1234,    1'b0, 1'b0};
        vt[7]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd7,  5'd0,  32'h1234,      32'h0,       1'b1, 1'b0};
        vt[8]  = '{2'b10, 5'd0,  32'h0,         5'd7,  32'hBEEF,   1'b0, 5'd0,  1'b0, 5'd7,  5'd0,  32'hBEEF,      32'h0,       1'b0, 1'b0};
        vt[9]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd7,  5'd0,  32'hBEEF,      32'h0,       1'b0, 1'b0};
        vt[10] = '{2'b11, 5'd31, 32'hCAFE,      5'd30, 32'hF00D,   1'b0, 5'd0,  1'b0, 5'd31, 5'd30, 32'hCAFE,      32'hF00D,    1'b0, 1'b0};
        vt[11] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd30, 5'd31, 32'hF00D,      32'hCAFE,    1'b0, 1'b0};
        vt[12] = '{2'b11, 5'd12, 32'h11,        5'd13, 32'h22,     1'b0, 5'd0,  1'b0, 5'd13, 5'd12, 32'h22,        32'h11,      1'b0, 1'b0};
        vt[13] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b1, 5'd12, 1'b0, 5'd12, 5'd13, 32'h11,        32'h22,      1'b0, 1'b0};
        vt[14] = '{2'b10, 5'd0,  32'h0,         5'd12, 32'h33,     1'b0, 5'd0,  1'b0, 5'd12, 5'd12, 32'h33,        32'h33,      1'b0, 1'b0};
        vt[15] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd12, 5'd13, 32'h33,        32'h22,      1'b0, 1'b0};
        vt[16] = '{2'b01, 5'd9,  32'h77,        5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h77,        32'h77,      1'b0, 1'b0};
        vt[17] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b1, 5'd20, 1'b0, 5'd20, 5'd0,  32'h0,         32'h0,       1'b0, 1'b0};
        vt[18] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd20, 5'd9,  32'h0,         32'h77,      1'b1, 1'b0};
        vt[19] = '{2'b11, 5'd20, 32'h1,         5'd20, 32'h2,      1'b1, 5'd20, 1'b0, 5'd20, 5'd0,  32'h2,         32'h0,       1'b0, 1'b0};
        vt[20] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,      1'b0, 5'd0,  1'b0, 5'd20, 5'd0,  32'h2,         32'h0,       1'b1, 1'b0};

        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0;
        rsv_addr = '0; clr_req = 1'b0; rd_addr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Power-up sweep: 32 cycles not ready, reads and stalls held at 0.
        for (int k = 0; k < 32; k++) begin
            v = vz(); v.rsv = 1'b1; v.rsva = 5'd7; v.ra0 = 5'd5; v.ra3 = 5'd31;
            run_cycle(v, "init_sweep", 1'b0);
        end
        v = vz(); v.ra0 = 5'd5; v.ra3 = 5'd31;
        run_cycle(v, "init_ready", 1'b1);

        for (int i = 0; i < 21; i++)
            run_cycle(vt[i], $sformatf("vec%0d", i), 1'b1);

        // Clear request beats a same-cycle write and reservation.
        v = vz(); v.clr = 1'b1; v.we = 2'b01; v.wa0 = 5'd3; v.wd0 = 32'h12;
        v.rsv = 1'b1; v.rsva = 5'd21; v.ra0 = 5'd3; v.ra3 = 5'd20; v.e3 = 32'h2;
        run_cycle(v, "clr_req", 1'b1);
        for (int k = 0; k < 32; k++) begin
            v = vz(); v.we = 2'b11; v.wa0 = 5'd3; v.wd0 = 32'h99; v.wa1 = 5'd20; v.wd1 = 32'h55;
            v.rsv = 1'b1; v.rsva = 5'd20; v.ra0 = (k % 2 == 1) ? 5'd20 : 5'd3; v.ra3 = 5'd5;
            run_cycle(v, "clr_sweep", 1'b0);
        end
        v = vz(); v.ra0 = 5'd3; v.ra3 = 5'd5;
        run_cycle(v, "post_clr_r3", 1'b1);
        v = vz(); v.rsv = 1'b1; v.rsva = 5'd20; v.ra0 = 5'd20; v.ra3 = 5'd31;
        run_cycle(v, "post_clr_rsv", 1'b1);
        v = vz(); v.ra0 = 5'd20; v.eb0 = 1'b1;
        run_cycle(v, "post_clr_busy", 1'b1);

        // Reset in the middle of a sweep restarts it from index 0.
        v = vz(); v.clr = 1'b1; v.ra0 = 5'd20; v.eb0 = 1'b1;
        run_cycle(v, "clr2", 1'b1);
        for (int k = 0; k < 10; k++) begin
            v = vz(); v.ra0 = 5'd20;
            run_cycle(v, "sweep_a", 1'b0);
        end
        rst = 1'b1; wr_en = '0; rsv_en = 1'b0; clr_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            v = vz(); v.ra0 = 5'd9; v.ra3 = 5'd12;
            run_cycle(v, "sweep_b", 1'b0);
        end
        v = vz(); v.ra0 = 5'd9; v.ra3 = 5'd12;
        run_cycle(v, "after_rst", 1'b1);

        v = vz();
        run_cycle(v, "idle", 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
